// File: rtl/digit_write_scheduler.sv
// digit_write_scheduler
//
// Purpose: serialises digit writes from three requesters into a 4-digit
// scanning seven-segment driver. After reset it blanks all four digits in
// turn. After that it grants one pending write at a time, in round-robin
// order, and holds the write's number/currLED stable for HOLD_CYCLES cycles
// so the driver latches it when its scan reaches the selected digit.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous, active-low reset
//   req[2:0]              level request per requester
//   req_digit0..2 [1:0]   target digit index (0 = leftmost)
//   req_value0..2 [3:0]   value to write (10..15 display blank)
//   ack[2:0]              one-cycle completion pulse to the granted requester
//   busy                  high whenever the scheduler is not idle
//   number[3:0]           to driver `number`
//   currLED[3:0]          to driver `currLED`, one-hot or 0000
module digit_write_scheduler #(
  parameter int cycleBits   = 21,
  parameter int HOLD_CYCLES = 1600004
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [1:0] req_digit0,
  input  logic [1:0] req_digit1,
  input  logic [1:0] req_digit2,
  input  logic [3:0] req_value0,
  input  logic [3:0] req_value1,
  input  logic [3:0] req_value2,
  output logic [2:0] ack,
  output logic       busy,
  output logic [3:0] number,
  output logic [3:0] currLED
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_HOLD} state_t;

  localparam logic [cycleBits-1:0] CNT_ONE   = cycleBits'(1);
  localparam logic [cycleBits-1:0] HOLD_LAST = cycleBits'(HOLD_CYCLES);
  localparam logic [cycleBits-1:0] HOLD_PRE  = cycleBits'(HOLD_CYCLES - 1);
  localparam logic [3:0]           BLANK     = 4'hA;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           win_q, win_d;
  logic [1:0]           dig_q, dig_d;
  logic [3:0]           val_q, val_d;
  logic [cycleBits-1:0] cnt_q, cnt_d;
  logic [2:0]           ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [3:0]           number_q, number_d;
  logic [3:0]           led_q, led_d;

  logic                 grant_vld;
  logic [1:0]           grant_id;
  logic [1:0]           cand;
  logic [1:0]           sel_dig;
  logic [3:0]           sel_val;

  function automatic logic [3:0] digit_onehot(input logic [1:0] d);
    case (d)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] ack_onehot(input logic [1:0] w);
    case (w)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Round-robin pick: walk from the farthest candidate back to ptr so the
  // candidate closest to ptr is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ptr_q;
    cand      = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = add_mod3(ptr_q, 2'(k));
      if (req_at(req, cand)) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    case (grant_id)
      2'd0:    begin sel_dig = req_digit0; sel_val = req_value0; end
      2'd1:    begin sel_dig = req_digit1; sel_val = req_value1; end
      default: begin sel_dig = req_digit2; sel_val = req_value2; end
    endcase
  end

  // Outputs are computed for the state being entered, so the registered
  // outputs always describe the current state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    dig_d    = dig_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    ack_d    = 3'b000;
    busy_d   = busy_q;
    number_d = number_q;
    led_d    = led_q;

    case (state_q)
      ST_INIT: begin
        // cnt_q is 0 only in the reset cycle; 1..HOLD_CYCLES count the
        // cycles already shown for the current blanking index.
        busy_d   = 1'b1;
        number_d = BLANK;
        if (cnt_q == HOLD_LAST) begin
          if (idx_q == 2'd3) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            led_d   = 4'b0000;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 2'd1;
            cnt_d = CNT_ONE;
            led_d = digit_onehot(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          led_d = digit_onehot(idx_q);
        end
      end

      ST_IDLE: begin
        led_d  = 4'b0000;
        busy_d = 1'b0;
        if (grant_vld) begin
          state_d  = ST_HOLD;
          win_d    = grant_id;
          dig_d    = sel_dig;
          val_d    = sel_val;
          cnt_d    = CNT_ONE;
          ptr_d    = add_mod3(grant_id, 2'd1);
          number_d = sel_val;
          led_d    = digit_onehot(sel_dig);
          busy_d   = 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          led_d   = 4'b0000;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          // Raise ack for the final hold cycle.
          if (cnt_q == HOLD_PRE) ack_d = ack_onehot(win_q);
        end
      end

      default: begin
        state_d = ST_INIT;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_INIT;
      idx_q    <= 2'd0;
      ptr_q    <= 2'd0;
      win_q    <= 2'd0;
      dig_q    <= 2'd0;
      val_q    <= 4'd0;
      cnt_q    <= '0;
      ack_q    <= 3'b000;
      busy_q   <= 1'b1;
      number_q <= BLANK;
      led_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      dig_q    <= dig_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      number_q <= number_d;
      led_q    <= led_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign number  = number_q;
  assign currLED = led_q;

endmodule

// File: tb/tb_digit_write_scheduler.sv
// Testbench for digit_write_scheduler with a short hold time. A timeline
// model (cycle number since reset release, grant time, round-robin pointer)
// predicts every output each cycle; requesters follow the req/ack protocol.
module tb_digit_write_scheduler;

  localparam int H  = 8;
  localparam int CB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [1:0] req_digit0, req_digit1, req_digit2;
  logic [3:0] req_value0, req_value1, req_value2;
  logic [2:0] ack;
  logic       busy;
  logic [3:0] number;
  logic [3:0] currLED;

  digit_write_scheduler #(.cycleBits(CB), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_digit0(req_digit0), .req_digit1(req_digit1), .req_digit2(req_digit2),
    .req_value0(req_value0), .req_value1(req_value1), .req_value2(req_value2),
    .ack(ack), .busy(busy), .number(number), .currLED(currLED)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requesters
  logic       pend [3];
  logic [1:0] dig  [3];
  logic [3:0] val  [3];
  logic       arm  [3];
  logic [1:0] arm_dig [3];
  logic [3:0] arm_val [3];
  logic       rand_mode;

  // Model
  int         c;
  logic       m_act;
  int         m_t;
  int         m_win;
  logic [1:0] m_dig;
  logic [3:0] m_val;
  logic [3:0] m_last;
  int         m_ptr;
  logic       granted_now;
  logic [2:0] e_ack_prev;
  int         ack_order[$];

  function automatic logic [3:0] map(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction

  task automatic drive_reqs();
    req        = {pend[2], pend[1], pend[0]};
    req_digit0 = dig[0];
    req_digit1 = dig[1];
    req_digit2 = dig[2];
    req_value0 = val[0];
    req_value1 = val[1];
    req_value2 = val[2];
  endtask

  task automatic post(input int i, input logic [1:0] d, input logic [3:0] v);
    arm[i]     = 1'b1;
    arm_dig[i] = d;
    arm_val[i] = v;
  endtask

  task automatic model_exp(output logic [3:0] en, output logic [3:0] el,
                           output logic [2:0] ea, output logic eb);
    if (c == 0) begin
      en = 4'hA; el = 4'b0000; ea = 3'b000; eb = 1'b1;
    end else if (c <= 4 * H) begin
      en = 4'hA; el = map(2'((c - 1) / H)); ea = 3'b000; eb = 1'b1;
    end else if (m_act && c > m_t && c <= m_t + H) begin
      en = m_val; el = map(m_dig);
      ea = (c == m_t + H) ? (3'b001 << m_win) : 3'b000;
      eb = 1'b1;
    end else begin
      en = m_last; el = 4'b0000; ea = 3'b000; eb = 1'b0;
    end
  endtask

  task automatic decide();
    granted_now = 1'b0;
    if (c > 4 * H && !(m_act && c <= m_t + H)) begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (pend[i]) begin
          granted_now = 1'b1;
          m_act  = 1'b1;
          m_t    = c;
          m_win  = i;
          m_dig  = dig[i];
          m_val  = val[i];
          m_last = val[i];
          m_ptr  = (i + 1) % 3;
          break;
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] en, el;
    logic [2:0] ea;
    logic       eb;
    @(posedge clk);
    #1;
    c++;
    model_exp(en, el, ea, eb);
    chk("number", number, en);
    chk("currLED", currLED, el);
    chk("ack", ack, ea);
    chk("busy", busy, eb);
    case (ack)
      3'b001:  ack_order.push_back(0);
      3'b010:  ack_order.push_back(1);
      3'b100:  ack_order.push_back(2);
      default: ;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (e_ack_prev[i]) pend[i] = 1'b0;
      if (arm[i] && !pend[i]) begin
        pend[i] = 1'b1; dig[i] = arm_dig[i]; val[i] = arm_val[i]; arm[i] = 1'b0;
      end else if (rand_mode && !pend[i] && !arm[i] && $urandom_range(0, 3) == 0) begin
        pend[i] = 1'b1; dig[i] = 2'($urandom); val[i] = 4'($urandom);
      end
      if (rand_mode && pend[i] && m_act && i == m_win && c > m_t && c <= m_t + H &&
          $urandom_range(0, 3) == 0) begin
        dig[i] = 2'($urandom); val[i] = 4'($urandom);
      end
    end
    drive_reqs();
    decide();
    e_ack_prev = ea;
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    granted_now = 1'b0;
    do begin
      step();
      n++;
    end while (!granted_now && n < 60);
    if (!granted_now) chk({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    m_act       = 1'b0;
    m_ptr       = 0;
    m_last      = 4'hA;
    e_ack_prev  = 3'b000;
    granted_now = 1'b0;
    #1;
    chk("rst_number", number, 4'hA);
    chk("rst_currLED", currLED, 4'b0000);
    chk("rst_ack", ack, 3'b000);
    chk("rst_busy", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_number", number, 4'hA);
    chk("rst_hold_currLED", currLED, 4'b0000);
    chk("rst_hold_ack", ack, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    c   = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    rand_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0; dig[i] = 2'd0; val[i] = 4'd0;
      arm[i] = 1'b0; arm_dig[i] = 2'd0; arm_val[i] = 4'd0;
    end
    m_t = 0; m_win = 0; m_dig = 2'd0; m_val = 4'd0;
    drive_reqs();
    #2;
    do_reset();

    // INIT sweep with all three requests raised early; round-robin 0,1,2 twice
    repeat (5) step();
    post(0, 2'd1, 4'd4); post(1, 2'd3, 4'd5); post(2, 2'd0, 4'd6);
    repeat (70) step();
    post(0, 2'd2, 4'd1); post(1, 2'd0, 4'd2); post(2, 2'd3, 4'd3);
    repeat (32) step();
    chk("rr_count", ack_order.size(), 6);
    for (int k = 0; k < 6 && k < ack_order.size(); k++)
      chk($sformatf("rr_order%0d", k), ack_order[k], k % 3);

    // Single write: digit 2, value 7
    post(0, 2'd2, 4'd7);
    wait_grant("single");
    step();
    chk("single_led", currLED, 4'b0010);
    chk("single_num", number, 4'h7);
    repeat (7) step();
    chk("single_ack", ack, 3'b001);
    step();
    chk("single_idle_led", currLED, 4'b0000);
    chk("single_idle_busy", busy, 1'b0);

    // Requester value changes during HOLD
    post(1, 2'd1, 4'd3);
    wait_grant("chg");
    repeat (3) step();
    val[1] = 4'd9;
    drive_reqs();
    repeat (5) step();
    chk("chg_num", number, 4'h3);
    chk("chg_ack", ack, 3'b010);
    step();

    // Reset in hold cycle 4, pending request granted after INIT reruns
    post(2, 2'd3, 4'd8);
    wait_grant("rst");
    repeat (4) step();
    do_reset();
    wait_grant("regrant");
    step();
    chk("regrant_led", currLED, 4'b0001);
    chk("regrant_num", number, 4'h8);

    // Back-to-back: requester 2 re-requests right after its ack
    post(2, 2'd1, 4'd5);
    repeat (8) step();
    step();
    chk("b2b_led", currLED, 4'b0100);
    chk("b2b_num", number, 4'h5);
    repeat (12) step();

    // Randomised traffic
    rand_mode = 1'b1;
    repeat (2000) step();
    rand_mode = 1'b0;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
